mvau_weight_stream: RTL

//  Multi-PE weight store and streamer for the MVAU. Holds PE banks of WMEM_DEPTH words,

---
 rtl/mvau_wmem_pkg.sv | 14 +
 rtl/mvau_weight_bank.sv | 56 +++++
 rtl/mvau_weight_stream.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mvau_wmem_pkg.sv
// Shared constants, helpers and the FIFO entry shape for the MVAU weight streamer.
`ifndef MVAU_WMEM_FIFO_ENTRY_T
`define MVAU_WMEM_FIFO_ENTRY_T(DW) struct packed { logic wrap; logic [(DW)-1:0] data; }
`endif

package mvau_wmem_pkg;

  localparam int FIFO_DEPTH = 2;

  function automatic int wmem_addr_bw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mvau_weight_bank.sv
// One weight bank with a registered synchronous read; contents come from INIT_WORDS.
// With MVAU_WMEM_RUNTIME_WR_EN defined the bank also accepts single-cycle writes.
module mvau_weight_bank #(
  parameter int SIMD       = 2,
  parameter int TW         = 1,
  parameter int WMEM_DEPTH = 4,
  parameter int ADDR_BW    = 2,
  parameter logic [WMEM_DEPTH*SIMD*TW-1:0] INIT_WORDS = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
`ifdef MVAU_WMEM_RUNTIME_WR_EN
  input  logic                  wr_en_i,
  input  logic [ADDR_BW-1:0]    wr_addr_i,
  input  logic [SIMD*TW-1:0]    wr_data_i,
`endif
  input  logic                  rd_en_i,
  input  logic [ADDR_BW-1:0]    rd_addr_i,
  output logic [SIMD*TW-1:0]    rd_data_o
);

  localparam int W = SIMD * TW;

  logic [W-1:0] words [WMEM_DEPTH];
  logic [W-1:0] rd_data_q;

`ifdef MVAU_WMEM_RUNTIME_WR_EN
  logic [W-1:0] mem_q [WMEM_DEPTH];

  // Reset reloads the initial image, so runtime writes last until the next reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int a = 0; a < WMEM_DEPTH; a++) mem_q[a] <= INIT_WORDS[a*W +: W];
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar a = 0; a < WMEM_DEPTH; a++) begin : g_word
    assign words[a] = mem_q[a];
  end
`else
  for (genvar a = 0; a < WMEM_DEPTH; a++) begin : g_word
    assign words[a] = INIT_WORDS[a*W +: W];
  end
`endif

  // Nonblocking update makes a same-cycle write/read read-first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= words[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mvau_weight_stream.sv
// MVAU weight streamer: PE banks read in lockstep at a self-generated wrapping address,
// buffered in a 2-entry FIFO, emitted on valid/ready. Optional macro: MVAU_WMEM_RUNTIME_WR_EN.
module mvau_weight_stream
  import mvau_wmem_pkg::*;
#(
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = wmem_addr_bw(WMEM_DEPTH),
  parameter logic [PE*WMEM_DEPTH*SIMD*TW-1:0] INIT_DATA = '0,
  localparam int PE_BW       = (PE > 1) ? $clog2(PE) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
`ifdef MVAU_WMEM_RUNTIME_WR_EN
  input  logic                     wmem_wr_en,
  input  logic [PE_BW-1:0]         wmem_wr_pe,
  input  logic [WMEM_ADDR_BW-1:0]  wmem_wr_addr,
  input  logic [SIMD*TW-1:0]       wmem_wr_data,
`endif
  input  logic                     wmem_en,
  input  logic                     wmem_restart,
  output logic                     wmem_out_v,
  input  logic                     wmem_out_rdy,
  output logic [PE*SIMD*TW-1:0]    wmem_out,
  output logic                     wmem_wrap
);

  localparam int W      = SIMD * TW;
  localparam int OUT_W  = PE * W;
  localparam int PTR_BW = $clog2(FIFO_DEPTH);
  localparam int OCC_BW = PTR_BW + 2;

  typedef `MVAU_WMEM_FIFO_ENTRY_T(OUT_W) fifo_entry_t;

  logic [WMEM_ADDR_BW-1:0] rd_addr_q, rd_addr_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_wrap_q, inflight_wrap_d;
  logic [PTR_BW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_BW:0]         count_q, count_d;
  fifo_entry_t             fifo_q [FIFO_DEPTH];
  logic [OUT_W-1:0]        bank_rdata;
  logic [OCC_BW-1:0]       occupancy;
  logic                    issue, push, pop, last_addr;

  for (genvar p = 0; p < PE; p++) begin : g_bank
`ifdef MVAU_WMEM_RUNTIME_WR_EN
    logic bank_wr_en;
    // Out-of-range bank selects match no instance and are dropped.
    assign bank_wr_en = wmem_wr_en && (wmem_wr_pe == PE_BW'(p));
`endif
    mvau_weight_bank #(
      .SIMD       (SIMD),
      .TW         (TW),
      .WMEM_DEPTH (WMEM_DEPTH),
      .ADDR_BW    (WMEM_ADDR_BW),
      .INIT_WORDS (INIT_DATA[p*WMEM_DEPTH*W +: WMEM_DEPTH*W])
    ) u_bank (
      .aclk      (aclk),
      .aresetn   (aresetn),
`ifdef MVAU_WMEM_RUNTIME_WR_EN
      .wr_en_i   (bank_wr_en),
      .wr_addr_i (wmem_wr_addr),
      .wr_data_i (wmem_wr_data),
`endif
      .rd_en_i   (issue),
      .rd_addr_i (rd_addr_q),
      .rd_data_o (bank_rdata[p*W +: W])
    );
  end

  assign wmem_out_v = (count_q != '0);
  assign pop        = wmem_out_v && wmem_out_rdy;
  assign push       = inflight_q;
  assign last_addr  = (rd_addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

  // The slot freed by this cycle's pop counts as free, which keeps 1 word/cycle.
  assign occupancy = OCC_BW'(count_q) + OCC_BW'(inflight_q) - OCC_BW'(pop);
  assign issue     = wmem_en && !wmem_restart && (occupancy < OCC_BW'(FIFO_DEPTH));

  always_comb begin
    rd_addr_d       = rd_addr_q;
    inflight_d      = issue;
    inflight_wrap_d = last_addr;
    wr_ptr_d        = wr_ptr_q + PTR_BW'(push);
    rd_ptr_d        = rd_ptr_q + PTR_BW'(pop);
    count_d         = count_q + (PTR_BW+1)'(push) - (PTR_BW+1)'(pop);
    if (issue) rd_addr_d = last_addr ? '0 : rd_addr_q + 1'b1;
    if (wmem_restart) begin
      rd_addr_d  = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_wrap_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_wrap_q <= inflight_wrap_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // A push never targets the head while it is presented, so stalled output holds.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push && !wmem_restart) begin
      fifo_q[wr_ptr_q].wrap <= inflight_wrap_q;
      fifo_q[wr_ptr_q].data <= bank_rdata;
    end
  end

  assign wmem_out  = wmem_out_v ? fifo_q[rd_ptr_q].data : '0;
  assign wmem_wrap = wmem_out_v && fifo_q[rd_ptr_q].wrap;

endmodule
